mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Sequencer for the execute-stage multiply/divide unit feeding the HI/LO path.
//  Accepts one MULT/MULTU/DIV/DIVU per request, runs a pipelined multiply or a
//  32-step radix-2 restoring divide, and holds the pipeline through the hazard
//  unit's mult/div stall input until {HI,LO} is ready. Sits beside the ALU in
//  E stage; its hi/lo outputs feed the M-stage HI/LO pipeline register.
// PARAMETERS
//  MUL_CYCLES  2   multiply latency in cycles, start to result_valid (>=1)
//  DIV_CYCLES  32  divide iterations; fixed at 32 for 32-bit operands
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous reset, active-low (0 = reset)
//  start         in   1   E-stage instruction is mult/div; level, held while stalled
//  op            in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a             in   32  rs operand (forwarded); dividend for divides
//  b             in   32  rt operand (forwarded); divisor for divides
//  cancel        in   1   flush of E stage; aborts the operation in progress
//  hold          in   1   downstream stall; keeps the result presented
//  stall         out  1   to hazard unit; freezes F/D/E while the unit is busy
//  result_valid  out  1   hi/lo carry a new result this cycle
//  hi            out  32  product[63:32] or remainder
//  lo            out  32  product[31:0] or quotient
//  div_by_zero   out  1   current result came from a divide with b==0
// BEHAVIOUR
//  - Reset: state IDLE; stall=0, result_valid=0, hi=lo=0, div_by_zero=0.
//  - States: IDLE, MUL, DIV, DONE.
//  - IDLE: start&!cancel captures op/a/b at edge T. Multiplies go to MUL and
//    divides with b!=0 go to DIV. Divides with b==0 go straight to DONE.
//  - MUL: counts MUL_CYCLES-1 cycles, then goes to DONE. result_valid is high
//    in cycle T+MUL_CYCLES. Signed and unsigned use 64-bit two's complement.
//  - DIV: works on operand magnitudes, one quotient bit per cycle over
//    DIV_CYCLES cycles. Signs are fixed up on the last iteration edge: the
//    quotient is negated if the signs of a and b differ, and the remainder
//    takes the sign of a. DONE and result_valid fall in cycle T+DIV_CYCLES+1.
//    The case 0x80000000 / -1 gives lo=0x80000000, hi=0, with no flag.
//  - Divide by zero: lo=0xFFFFFFFF, hi=a, div_by_zero=1, DONE at T+1.
//  - stall = !cancel & ((IDLE & start) | MUL | DIV). It is combinational and
//    low in DONE, so the held instruction leaves E at the end of the DONE cycle.
//  - DONE: result_valid=1. With hold=0 the state returns to IDLE next edge;
//    with hold=1 it stays in DONE and hi/lo stay stable. start is ignored in
//    DONE, because it is the same instruction, so nothing is re-issued.
//  - cancel (highest priority, any state): next state is IDLE, stall is
//    forced low in the same cycle, and the result is discarded
//    (result_valid=0). hi, lo and div_by_zero keep their previous values.
//  - hi/lo/div_by_zero are registered; they update only on entry to DONE and
//    keep their value in IDLE.
//  - op, a and b are sampled only in IDLE. Changes while busy are ignored.
//  - Reset asserted mid-operation: immediate IDLE and all outputs 0, with no
//    partial result left.
// STRUCTURE
//  - mdu_pkg: op encodings (MDU_MULT..MDU_DIVU), state enum, DIV_CYCLES,
//    div-by-zero quotient constant 32'hFFFFFFFF.
//  - Sub-module mdu_div_core holds the remainder/quotient shift registers,
//    a 6-bit step counter and the sign fixup, with a start/done handshake.
//    mdu_ctrl holds the FSM, the multiply pipeline, the stall logic and the
//    output registers.
// TESTING
//  1 MULT a=0xFFFFFFFE b=3 at T -> stall high T..T+1; at T+2 result_valid=1,
//    hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  2 MULTU a=0xFFFFFFFE b=3 -> hi=0x00000002, lo=0xFFFFFFFA at T+2.
//  3 DIV a=0xFFFFFFF9 b=2 -> stall 33 cycles; at T+33 lo=0xFFFFFFFD,
//    hi=0xFFFFFFFF.
//  4 DIVU a=100 b=0 -> at T+1 result_valid=1, div_by_zero=1, lo=0xFFFFFFFF,
//    hi=100.
//  5 DIV 1000/7 with cancel at T+10 -> stall 0 in that cycle, IDLE next, no
//    result_valid, hi/lo unchanged; a following DIVU 1000/7 gives lo=142, hi=6.
//  6 DONE with hold=1 for 3 cycles and start=1 -> result_valid held, no restart;
//    in a separate run, rst=0 at T+5 of a DIV -> all outputs 0, IDLE.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings, state type and helpers for the E-stage multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } mdu_state_e;

    localparam int          DIV_CYCLES    = 32;
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    // Low 64 bits of the product of the sign/zero-extended operands.
    function automatic logic [63:0] mul64(input mdu_op_e op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {{32{op_is_signed(op) & a[31]}}, a};
        bx = {{32{op_is_signed(op) & b[31]}}, b};
        return ax * bx;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider on operand magnitudes; one quotient bit per cycle,
// signs applied to the values presented alongside done_o on the final step.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic        busy_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        qneg_q;
    logic        rneg_q;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // The dividend shifts out of quo_q into the partial remainder as quotient bits shift in.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fits    = ~diff[32];
    assign rem_nxt = fits ? diff[31:0] : shifted[31:0];
    assign quo_nxt = {quo_q[30:0], fits};

    assign done_o = busy_q && (cnt_q == 6'(DIV_CYCLES - 1));
    assign quo_o  = cond_neg(quo_nxt, qneg_q);
    assign rem_o  = cond_neg(rem_nxt, rneg_q);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= cond_neg(dividend_i, signed_i & dividend_i[31]);
            dvs_q  <= cond_neg(divisor_i, signed_i & divisor_i[31]);
            qneg_q <= signed_i & (dividend_i[31] ^ divisor_i[31]);
            rneg_q <= signed_i & dividend_i[31];
        end else if (busy_q) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + 6'd1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: FSM, multiply pipeline, hazard stall and
// the registered HI/LO result presented to the M-stage HI/LO register.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        hold,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    localparam int MCW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

    mdu_state_e  state_q;
    mdu_op_e     op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [MCW-1:0] mcnt_q;
    logic        valid_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        dbz_q;

    mdu_op_e     op_e;
    logic [63:0] prod;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    assign op_e = mdu_op_e'(op);

    // A single-cycle multiply has no MUL state, so it must read the live operands.
    assign prod = (MUL_CYCLES == 1) ? mul64(op_e, a, b) : mul64(op_q, a_q, b_q);

    assign div_start = (state_q == ST_IDLE) && start && !cancel && op_is_div(op_e)
                       && (b != '0);

    mdu_div_core u_div (
        .clk        (clk),
        .rst_n      (rst),
        .start_i    (div_start),
        .abort_i    (cancel),
        .signed_i   (op_is_signed(op_e)),
        .dividend_i (a),
        .divisor_i  (b),
        .done_o     (div_done),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    assign stall = rst && !cancel && (((state_q == ST_IDLE) && start)
                   || (state_q == ST_MUL) || (state_q == ST_DIV));
    assign result_valid = valid_q && !cancel;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign div_by_zero  = dbz_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= MDU_MULT;
            a_q     <= '0;
            b_q     <= '0;
            mcnt_q  <= '0;
            valid_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else if (cancel) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op_e;
                        a_q    <= a;
                        b_q    <= b;
                        mcnt_q <= '0;
                        if (!op_is_div(op_e)) begin
                            if (MUL_CYCLES == 1) begin
                                hi_q    <= prod[63:32];
                                lo_q    <= prod[31:0];
                                dbz_q   <= 1'b0;
                                valid_q <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                state_q <= ST_MUL;
                            end
                        end else if (b == '0) begin
                            hi_q    <= a;
                            lo_q    <= DIV0_QUOTIENT;
                            dbz_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (mcnt_q == MCW'(MUL_CYCLES - 2)) begin
                        hi_q    <= prod[63:32];
                        lo_q    <= prod[31:0];
                        dbz_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        mcnt_q <= mcnt_q + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        hi_q    <= div_rem;
                        lo_q    <= div_quo;
                        dbz_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start is still the same instruction here, so it never re-issues.
                    if (!hold) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a driver issues ops and queues the reference
// result, a negedge monitor pops and compares whenever result_valid is shown.
`timescale 1ns/1ps
module tb_mdu_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          issue;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic        hold = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    exp_t sb_q[$];
    exp_t m_e;
    logic        prev_rv = 1'b0;
    logic        hold_seen = 1'b0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    logic        last_dbz = 1'b0;

    mdu_ctrl #(.MUL_CYCLES(MUL_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .a            (a),
        .b            (b),
        .cancel       (cancel),
        .hold         (hold),
        .stall        (stall),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) hold_seen = hold;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from plain arithmetic on 64-bit values.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx;
        longint sy;
        longint sp;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dbz = 1'b0;
        e.issue = 0;
        e.lat = DIV_LAT;
        case (o)
            2'b00: begin
                sp = sx * sy;
                p = sp;
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.lat = MUL_LAT;
            end
            2'b01: begin
                p = {32'd0, x} * {32'd0, y};
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.lat = MUL_LAT;
            end
            default: begin
                if (y == 32'd0) begin
                    e.hi = x;
                    e.lo = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                    e.lat = 1;
                end else if (o == 2'b10) begin
                    sp = sx / sy;
                    e.lo = sp[31:0];
                    sp = sx % sy;
                    e.hi = sp[31:0];
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return 32'd7;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: new results are popped; held results and idle cycles must keep last value.
    always @(negedge clk) begin
        if (!rst) begin
            prev_rv = 1'b0;
            last_hi = '0;
            last_lo = '0;
            last_dbz = 1'b0;
        end else begin
            if (result_valid && prev_rv && hold_seen) begin
                check("held_hi", hi, last_hi);
                check("held_lo", lo, last_lo);
                check("held_dbz", div_by_zero, last_dbz);
            end else if (result_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got hi=0x%0h lo=0x%0h with no op outstanding",
                             hi, lo);
                end else begin
                    m_e = sb_q.pop_front();
                    check("result_hi", hi, m_e.hi);
                    check("result_lo", lo, m_e.lo);
                    check("result_dbz", div_by_zero, m_e.dbz);
                    check("latency", cyc - m_e.issue, m_e.lat);
                    last_hi = m_e.hi;
                    last_lo = m_e.lo;
                    last_dbz = m_e.dbz;
                end
            end else begin
                check("keep_hi", hi, last_hi);
                check("keep_lo", lo, last_lo);
                check("keep_dbz", div_by_zero, last_dbz);
            end
            prev_rv = result_valid;
        end
    end

    // Called just after a rising edge; returns just after a rising edge with the unit idle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int hold_n);
        exp_t e;
        bit   seen;
        e = model(o, x, y);
        e.issue = cyc;
        sb_q.push_back(e);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (result_valid) begin
                seen = 1'b1;
                check("stall_in_done", stall, 1'b0);
            end else begin
                check("stall_busy", stall, 1'b1);
                @(posedge clk);
                #1;
                op = 2'($urandom());
                a = $urandom();
                b = $urandom();
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL result_timeout: no result_valid within 60 cycles for op %0d", o);
            sb_q.delete();
            @(posedge clk);
            #1;
            start = 1'b0;
            return;
        end
        #1 hold = (hold_n > 0);
        for (int i = 1; i <= hold_n; i++) begin
            @(negedge clk);
            check("hold_valid", result_valid, 1'b1);
            check("hold_stall", stall, 1'b0);
            if (i == hold_n) #1 hold = 1'b0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom());
        a = $urandom();
        b = $urandom();
        @(negedge clk);
        check("idle_valid", result_valid, 1'b0);
        check("idle_stall", stall, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_cancel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                              input int cancel_k);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        for (int k = 1; k <= cancel_k; k++) begin
            @(posedge clk);
            #1;
        end
        cancel = 1'b1;
        @(negedge clk);
        check("cancel_stall", stall, 1'b0);
        check("cancel_valid", result_valid, 1'b0);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("after_cancel_stall", stall, 1'b0);
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic run_reset_mid(input int at_k);
        start = 1'b1;
        op = 2'b10;
        a = 32'd5000;
        b = 32'd3;
        for (int k = 1; k <= at_k; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_dbz", div_by_zero, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("reset_stall", stall, 1'b0);
        check("reset_valid", result_valid, 1'b0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_dbz", div_by_zero, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 0);
        run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b11, 32'd100, 32'd0, 0);
        run_cancel(2'b10, 32'd1000, 32'd7, 10);
        run_op(2'b11, 32'd1000, 32'd7, 0);
        run_op(2'b00, 32'd7, 32'd9, 3);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_op(2'b10, 32'd1000, 32'hFFFF_FFF9, 0);
        run_op(2'b10, 32'h8000_0000, 32'd0, 0);

        for (int n = 0; n < 40; n++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick(), $urandom_range(0, 2));
        end

        run_reset_mid(5);
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
